nn_image_loader: RTL and testbench
==================================

// Module: nn_image_loader
// PURPOSE
//  Upstream feeder for neural_network. Accepts one 28x28 frame of 8-bit pixels on a valid/ready stream.
//  Converts each pixel to a signed 32-bit fixed-point word and writes it into the writable image memory
//  (address 0..NUM_PIXELS-1), then pulses neural_network's start.
//  Waits for its done and latches the 4-bit argmax class for display/readout.
// PARAMETERS
//  NUM_PIXELS  784  words per frame; frame complete after this many accepted pixels
//  FRAC_BITS   16   fractional bits of written word; legal range 8..23
// PORTS
//  clk           in   1   system clock; all logic on posedge
//  reset         in   1   synchronous, active-high reset
//  pix_valid     in   1   pixel stream valid
//  pix_sof       in   1   start-of-frame marker, qualifies pixel 0; meaningful only with pix_valid
//  pix_data      in   8   unsigned pixel intensity 0..255
//  pix_ready     out  1   loader can accept a pixel this cycle
//  mem_we        out  1   image memory write enable
//  mem_addr      out  16  image memory write address
//  mem_data      out  32  image memory write data, signed fixed point
//  nn_start      out  1   one-cycle start pulse to neural_network
//  nn_done       in   1   neural_network done (one-cycle level)
//  nn_argmax     in   4   neural_network argmax_output
//  result        out  4   latched class of the last completed frame
//  result_valid  out  1   result holds a class from a completed frame
//  busy          out  1   high in any state other than IDLE
//  frame_err     out  1   one-cycle pulse on a framing fault
// BEHAVIOUR
//  - Reset state: every output is 0, except pix_ready = 1 (IDLE). The FSM goes to IDLE and the pixel counter to 0.
//  - Reset mid-operation: the same values apply on the next edge. A partial frame is abandoned, and result_valid is cleared.
//  - Transfer: xfer = pix_valid & pix_ready. pix_ready = 1 only in IDLE and LOAD; 0 in FLUSH, START, WAIT.
//  - Conversion: mem_data = {{(24-FRAC_BITS){1'b0}}, pix_data, {(FRAC_BITS-8){1'b0}}}.
//    This is pix/256 in Q(31-FRAC_BITS).FRAC_BITS. The result is always non-negative.
//  - Write latency: 1 cycle. An xfer in cycle T drives mem_we = 1 with that pixel's addr/data in T+1.
//    mem_we = 0 in every cycle not preceded by an xfer.
//  - States: IDLE, LOAD, FLUSH, START, WAIT.
//  - IDLE:
//    - xfer with pix_sof=1: pixel written to addr 0, count <= 1, go to LOAD, result_valid <= 0.
//    - xfer with pix_sof=0: pixel dropped (no write), frame_err pulses in T+1, stay in IDLE.
//  - LOAD:
//    - xfer with pix_sof=0: write to addr count, count++.
//    - xfer with pix_sof=1: resync. Write to addr 0, count <= 1, frame_err pulses in T+1.
//    - If the accepted pixel takes addr NUM_PIXELS-1 and has pix_sof=0, go to FLUSH.
//    - Gaps (pix_valid=0) are allowed indefinitely; count holds.
//  - FLUSH: exactly one cycle, in which the final write (mem_we, addr NUM_PIXELS-1) occurs. Then go to START.
//  - START: nn_start = 1 for exactly this one cycle. Then go to WAIT.
//    Because of this ordering, the final write is committed one cycle before the network samples start.
//  - WAIT: when nn_done = 1, result <= nn_argmax, result_valid <= 1, go to IDLE.
//  - nn_done or nn_argmax changes in any state other than WAIT are ignored.
//  - result/result_valid hold until reset or the next accepted sof.
//  - count width: clog2(NUM_PIXELS); mem_addr zero-extended to 16 bits.
// TESTING
//  1. Reset, then frame with pix_data = i%256 (sof on i=0, FRAC_BITS=16):
//     mem_we at addr i with data (i%256)<<8 for i = 0..783; nn_start 2 cycles after the last xfer; busy=1.
//  2. In WAIT, pulse nn_done with nn_argmax=7: result=7 and result_valid=1 on the next cycle, FSM in IDLE, pix_ready=1.
//  3. Random pix_valid gaps (~50%) during a frame: exactly 784 writes with contiguous addresses; no write on gap cycles.
//  4. sof reasserted at pixel 300: frame_err pulse, the next write goes to addr 0, and 784 further pixels are needed before nn_start.
//  5. Pixel with sof=0 in IDLE: no mem_we, frame_err = 1 for one cycle. Pixels offered in WAIT: pix_ready=0, no write.
//  6. reset at pixel 500: next cycle busy=0, mem_we=0, result_valid=0; a fresh frame then writes from addr 0 normally.

Source files
------------

// File: rtl/nn_image_loader_if.sv
// Pixel-stream / image-memory / network-handshake bundle for nn_image_loader.
// slave  : loader side (accepts pixels, drives memory writes, start, result, status).
// master : environment side (drives pixels and network done/argmax, observes the rest).
interface nn_image_loader_if;
  logic        pix_valid;
  logic        pix_sof;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_data;
  logic        nn_start;
  logic        nn_done;
  logic [3:0]  nn_argmax;
  logic [3:0]  result;
  logic        result_valid;
  logic        busy;
  logic        frame_err;

  modport slave (
    input  pix_valid, pix_sof, pix_data, nn_done, nn_argmax,
    output pix_ready, mem_we, mem_addr, mem_data, nn_start,
           result, result_valid, busy, frame_err
  );

  modport master (
    output pix_valid, pix_sof, pix_data, nn_done, nn_argmax,
    input  pix_ready, mem_we, mem_addr, mem_data, nn_start,
           result, result_valid, busy, frame_err
  );
endinterface

// File: rtl/nn_image_loader.sv
// Loads one frame of 8-bit pixels into image memory as fixed-point words, starts the network, latches its class.
// Latency: pixel accepted in cycle T is written in T+1; nn_start two cycles after the last pixel of a frame.
// Backpressure: pix_ready high only in IDLE/LOAD; held low from the final pixel until the network reports done.
// Ports: clk/reset (sync, active high); bus (slave modport): pixel stream in, memory write out,
//        nn_start/nn_done/nn_argmax handshake, result/result_valid readout, busy and frame_err status.
module nn_image_loader #(
  parameter int NUM_PIXELS = 784,
  parameter int FRAC_BITS  = 16
) (
  input  logic               clk,
  input  logic               reset,
  nn_image_loader_if.slave   bus
);

  localparam int CW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] count;
  logic          xfer;
  logic          last_pix;
  logic [31:0]   conv;

  logic          mem_we_q;
  logic [15:0]   mem_addr_q;
  logic [31:0]   mem_data_q;
  logic [3:0]    result_q;
  logic          result_valid_q;
  logic          frame_err_q;

  assign bus.pix_ready = (state == S_IDLE) || (state == S_LOAD);
  assign xfer          = bus.pix_valid && bus.pix_ready;
  assign last_pix      = (count == CW'(NUM_PIXELS - 1));

  // pix/256 placed so the pixel's MSB lands just below the binary point;
  // the upper bits stay zero, so the word is always non-negative.
  assign conv = 32'(bus.pix_data) << (FRAC_BITS - 8);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      count          <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      mem_we_q    <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            if (bus.pix_sof) begin
              mem_we_q       <= 1'b1;
              mem_addr_q     <= '0;
              mem_data_q     <= conv;
              count          <= CW'(1);
              result_valid_q <= 1'b0;
              state          <= S_LOAD;
            end else begin
              // Stray pixel outside a frame: dropped, flagged.
              frame_err_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (xfer) begin
            mem_we_q   <= 1'b1;
            mem_data_q <= conv;
            if (bus.pix_sof) begin
              // Resync: the new sof pixel restarts the frame at address 0.
              mem_addr_q     <= '0;
              count          <= CW'(1);
              frame_err_q    <= 1'b1;
              result_valid_q <= 1'b0;
            end else begin
              mem_addr_q <= 16'(count);
              if (last_pix) begin
                count <= '0;
                state <= S_FLUSH;
              end else begin
                count <= count + CW'(1);
              end
            end
          end
        end
        // The final write is on the bus during FLUSH, so it is committed
        // one cycle before the network samples nn_start.
        S_FLUSH: state <= S_START;
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (bus.nn_done) begin
            result_q       <= bus.nn_argmax;
            result_valid_q <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data     = mem_data_q;
  assign bus.nn_start     = (state == S_START);
  assign bus.busy         = (state != S_IDLE);
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_nn_image_loader.sv
// Testbench for nn_image_loader: directed sequence with randomized pixel data and stream gaps,
// checked against a frame-level reference (expected write list, start timing, class latching).
module tb_nn_image_loader;
  localparam int NPIX = 784;
  localparam int FRAC = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nn_image_loader_if bus();

  nn_image_loader #(.NUM_PIXELS(NPIX), .FRAC_BITS(FRAC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed activity, sampled mid-cycle.
  int          w_addr[$];
  logic [31:0] w_data[$];
  int          w_cyc[$];
  int          start_cyc[$];
  int          ferr_cyc[$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      w_addr.push_back(int'(bus.mem_addr));
      w_data.push_back(bus.mem_data);
      w_cyc.push_back(cyc);
    end
    if (bus.nn_start === 1'b1) start_cyc.push_back(cyc);
    if (bus.frame_err === 1'b1) ferr_cyc.push_back(cyc);
  end

  // Expected activity, built from the stimulus.
  int          x_cyc[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pix/256 expressed with FRAC fractional bits.
  function automatic logic [31:0] model_word(input int pix);
    return 32'(pix * (2 ** FRAC) / 256);
  endfunction

  task automatic clear_logs();
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    start_cyc.delete(); ferr_cyc.delete();
    x_cyc.delete(); exp_addr.delete(); exp_data.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one pixel until accepted; gap_pct percent of cycles are left idle.
  task automatic push_pix(input logic sof, input logic [7:0] d, input int gap_pct);
    bit done;
    bit acc;
    int guard;
    done  = 0;
    guard = 0;
    while (!done) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        bus.pix_valid = 1'b0;
      end else begin
        bus.pix_valid = 1'b1;
        bus.pix_sof   = sof;
        bus.pix_data  = d;
      end
      acc = (bus.pix_valid === 1'b1) && (bus.pix_ready === 1'b1);
      idle(1);
      if (acc) begin
        x_cyc.push_back(cyc - 1);
        done = 1;
      end
      guard++;
      if (!done && guard > 1000) begin
        chk("pix_accept_timeout", 32'(guard), 32'd0);
        done = 1;
      end
    end
    bus.pix_valid = 1'b0;
  endtask

  // Send n pixels of one frame segment; sof on the first, expected addresses from 0.
  task automatic send_seg(input int n, input int gap_pct, input bit ramp);
    logic [7:0] p;
    for (int i = 0; i < n; i++) begin
      p = ramp ? 8'(i % 256) : 8'($urandom_range(255));
      push_pix(i == 0, p, gap_pct);
      exp_addr.push_back(i);
      exp_data.push_back(model_word(int'(p)));
    end
  endtask

  task automatic wait_start(input string tag);
    int g;
    g = 0;
    while (start_cyc.size() == 0 && g < 20) begin
      idle(1);
      g++;
    end
    chk({tag, "_start_count"}, 32'(start_cyc.size()), 32'd1);
    if (start_cyc.size() > 0 && x_cyc.size() > 0)
      chk({tag, "_start_cycle"}, 32'(start_cyc[0]), 32'(x_cyc[x_cyc.size()-1] + 2));
    chk({tag, "_busy_wait"}, 32'(bus.busy), 32'd1);
    chk({tag, "_ready_wait"}, 32'(bus.pix_ready), 32'd0);
  endtask

  task automatic check_writes(input string tag);
    int n;
    int bad0;
    chk({tag, "_write_count"}, 32'(w_addr.size()), 32'(exp_addr.size()));
    n = (w_addr.size() < exp_addr.size()) ? w_addr.size() : exp_addr.size();
    bad0 = miscompares;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, 32'(w_addr[i]), 32'(exp_addr[i]));
      chk({tag, "_data"}, w_data[i], exp_data[i]);
      chk({tag, "_wr_latency"}, 32'(w_cyc[i]), 32'(x_cyc[i] + 1));
      if (miscompares != bad0) break;
    end
  endtask

  task automatic finish_frame(input logic [3:0] cls);
    bus.nn_done   = 1'b1;
    bus.nn_argmax = cls;
    idle(1);
    bus.nn_done   = 1'b0;
    bus.nn_argmax = 4'd0;
  endtask

  initial begin
    logic [3:0] cls;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_data  = 8'd0;
    bus.nn_done   = 1'b0;
    bus.nn_argmax = 4'd0;
    reset = 1'b1;
    #1;
    idle(3);

    // Reset state
    chk("rst_pix_ready", 32'(bus.pix_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_data", bus.mem_data, 32'd0);
    chk("rst_nn_start", 32'(bus.nn_start), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_result_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    reset = 1'b0;
    idle(1);

    // Ramp frame, back-to-back pixels
    clear_logs();
    send_seg(NPIX, 0, 1'b1);
    wait_start("ramp");
    check_writes("ramp");
    chk("ramp_frame_err", 32'(ferr_cyc.size()), 32'd0);

    // Done in WAIT latches the class
    finish_frame(4'd7);
    chk("done_result", 32'(bus.result), 32'd7);
    chk("done_result_valid", 32'(bus.result_valid), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_pix_ready", 32'(bus.pix_ready), 32'd1);

    // Done outside WAIT is ignored
    finish_frame(4'd12);
    chk("idle_done_result", 32'(bus.result), 32'd7);
    chk("idle_done_valid", 32'(bus.result_valid), 32'd1);
    chk("idle_done_busy", 32'(bus.busy), 32'd0);

    // Random data with ~50% stream gaps
    clear_logs();
    send_seg(NPIX, 50, 1'b0);
    chk("gap_result_valid_cleared", 32'(bus.result_valid), 32'd0);
    wait_start("gap");
    check_writes("gap");
    cls = 4'($urandom_range(15));
    finish_frame(cls);
    chk("gap_result", 32'(bus.result), 32'(cls));
    chk("gap_result_valid", 32'(bus.result_valid), 32'd1);

    // Resync: sof again at pixel 300
    clear_logs();
    send_seg(300, 20, 1'b0);
    send_seg(NPIX, 20, 1'b0);
    wait_start("resync");
    check_writes("resync");
    chk("resync_ferr_count", 32'(ferr_cyc.size()), 32'd1);
    if (ferr_cyc.size() > 0)
      chk("resync_ferr_cycle", 32'(ferr_cyc[0]), 32'(x_cyc[300] + 1));
    finish_frame(4'd5);
    chk("resync_result", 32'(bus.result), 32'd5);

    // Stray pixel in IDLE
    clear_logs();
    push_pix(1'b0, 8'h55, 0);
    chk("stray_mem_we", 32'(bus.mem_we), 32'd0);
    chk("stray_frame_err", 32'(bus.frame_err), 32'd1);
    chk("stray_busy", 32'(bus.busy), 32'd0);
    idle(1);
    chk("stray_frame_err_pulse", 32'(bus.frame_err), 32'd0);
    chk("stray_no_write", 32'(w_addr.size()), 32'd0);

    // Pixels offered while waiting for the network
    clear_logs();
    send_seg(NPIX, 0, 1'b0);
    wait_start("wait_offer");
    check_writes("wait_offer");
    bus.pix_valid = 1'b1;
    bus.pix_sof   = 1'b1;
    bus.pix_data  = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      chk("wait_pix_ready", 32'(bus.pix_ready), 32'd0);
      idle(1);
      chk("wait_mem_we", 32'(bus.mem_we), 32'd0);
    end
    bus.pix_valid = 1'b0;
    finish_frame(4'd9);
    chk("wait_result", 32'(bus.result), 32'd9);

    // Reset in the middle of a frame
    clear_logs();
    send_seg(500, 0, 1'b0);
    reset         = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_sof   = 1'b0;
    idle(1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_result_valid", 32'(bus.result_valid), 32'd0);
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_pix_ready", 32'(bus.pix_ready), 32'd1);
    reset         = 1'b0;
    bus.pix_valid = 1'b0;
    idle(1);
    clear_logs();
    send_seg(NPIX, 30, 1'b0);
    wait_start("postrst");
    check_writes("postrst");
    finish_frame(4'd3);
    chk("postrst_result", 32'(bus.result), 32'd3);
    chk("postrst_result_valid", 32'(bus.result_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
